// File: rtl/am_audio_pkg.sv
// am_audio_pkg: shared defaults, saturation limits and clip helper for the AM audio path
package am_audio_pkg;

    localparam int WIDTH_DEF = 12;

    function automatic logic signed [31:0] sat_max(input int width);
        return (32'sd1 <<< (width - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int width);
        return -(32'sd1 <<< (width - 1));
    endfunction

    localparam logic signed [31:0] SAT_MAX = sat_max(WIDTH_DEF);
    localparam logic signed [31:0] SAT_MIN = sat_min(WIDTH_DEF);

    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] value, input int width);
        return value > sat_max(width) ? sat_max(width) :
               value < sat_min(width) ? sat_min(width) : value;
    endfunction

endpackage

// File: rtl/pwm_dac.sv
// pwm_dac: free-running PWM with a pending level that only reaches the duty register at the period wrap
//   clk, rst_n  clock, async active-low reset
//   level_in    offset-binary level, PWM_BITS wide
//   level_vld   latches level_in as the pending duty (latest wins)
//   pwm_out     registered (cnt < duty)
module pwm_dac
    import am_audio_pkg::*;
#(
    parameter int PWM_BITS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] level_in,
    input  logic                level_vld,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0] cnt, pend, duty;

    // duty only moves at the wrap so a period is never split between two levels;
    // a level arriving in the wrap cycle lands in pend and waits for the next wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pend    <= MID;
            duty    <= MID;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + PWM_BITS'(1);
            if (level_vld) pend <= level_in;
            if (cnt == '1) duty <= pend;
            pwm_out <= cnt < duty;
        end
    end

endmodule

// File: rtl/am_audio_out.sv
// am_audio_out: DC-blocks the AM envelope, applies power-of-2 gain with saturation, drives a PWM DAC
//   clk, rst_n  clock, async active-low reset
//   d_in        unsigned envelope sample, d_valid qualifies it
//   audio_out   signed audio sample, updated with the one-cycle audio_vld strobe
//   sat         strobes with audio_vld when the sample was clipped
//   pwm_out     1-bit PWM DAC pin
module am_audio_out
    import am_audio_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DC_SHIFT   = 10,
    parameter int GAIN_SHIFT = 0,
    parameter int PWM_BITS   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             d_valid,
    output logic [WIDTH-1:0] audio_out,
    output logic             audio_vld,
    output logic             sat,
    output logic             pwm_out
);

    localparam int AW = WIDTH + DC_SHIFT;
    localparam int GW = WIDTH + 1 + GAIN_SHIFT;

    logic [AW-1:0]          acc;
    logic [WIDTH-1:0]       dc;
    logic signed [WIDTH:0]  diff;
    logic                   v1;
    logic signed [GW-1:0]   g;
    logic signed [31:0]     g32, clip;
    logic [WIDTH-1:0]       ob;
    logic [PWM_BITS-1:0]    level;

    always_comb begin
        dc    = WIDTH'(acc >> DC_SHIFT);
        g     = GW'(diff) <<< GAIN_SHIFT;
        g32   = 32'(g);
        clip  = sat_clip(g32, WIDTH);
        ob    = audio_out ^ {1'b1, {(WIDTH-1){1'b0}}};
        level = PWM_BITS'(ob >> (WIDTH - PWM_BITS));
    end

    // the stage-1 diff uses dc from before this sample's acc update, since both
    // are sampled on the same edge; acc stays in range because the leak matches
    // the input at full scale, so the modular add/sub never wraps the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            diff      <= '0;
            v1        <= 1'b0;
            audio_out <= '0;
            audio_vld <= 1'b0;
            sat       <= 1'b0;
        end else begin
            if (d_valid) begin
                acc  <= acc + AW'(d_in) - AW'(dc);
                diff <= $signed({1'b0, d_in}) - $signed({1'b0, dc});
            end
            v1        <= d_valid;
            audio_vld <= v1;
            sat       <= v1 && (clip != g32);
            if (v1) audio_out <= clip[WIDTH-1:0];
        end
    end

    pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .level_in (level),
        .level_vld(audio_vld),
        .pwm_out  (pwm_out)
    );

endmodule

// File: tb/tb_am_audio_out.sv
// tb_am_audio_out: scoreboard bench for am_audio_out (default, gain-2 and DC_SHIFT=0 builds)
module tb_am_audio_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] d_in;
    logic        d_valid;
    logic [11:0] a0, ag, ad;
    logic        v0, vg, vd, s0, sg, sd, p0, pg, pd;

    always #5 clk = ~clk;

    am_audio_out dut0 (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
        .audio_out(a0), .audio_vld(v0), .sat(s0), .pwm_out(p0));

    am_audio_out #(.GAIN_SHIFT(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
        .audio_out(ag), .audio_vld(vg), .sat(sg), .pwm_out(pg));

    am_audio_out #(.DC_SHIFT(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_valid(d_valid),
        .audio_out(ad), .audio_vld(vd), .sat(sd), .pwm_out(pd));

    int          checks = 0;
    int          errors = 0;
    logic [12:0] sb[$];
    logic [12:0] e;
    int          acc_m = 0;

    // scoreboard for the default build: {sat, audio} per accepted sample
    always @(negedge clk) begin
        if (rst_n === 1'b1 && v0 === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_vld got audio=%0d with no sample pending", $signed(a0));
            end else begin
                e = sb.pop_front();
                if ({s0, a0} !== e) begin
                    errors++;
                    $display("FAIL sb_sample got sat=%0b audio=%0d expected sat=%0b audio=%0d",
                             s0, $signed(a0), e[12], $signed(e[11:0]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // call at a negedge; holds inputs for one cycle, returns at the next negedge
    task automatic drive(input logic v, input logic [11:0] d);
        int dc, diff, ex;
        logic se;
        d_valid = v;
        d_in    = d;
        if (v) begin
            dc    = acc_m >> 10;
            diff  = int'(d) - dc;
            se    = diff > 2047 || diff < -2048;
            ex    = diff > 2047 ? 2047 : diff < -2048 ? -2048 : diff;
            sb.push_back({se, ex[11:0]});
            acc_m = acc_m + int'(d) - dc;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        sb.delete();
        acc_m   = 0;
        d_valid = 1'b0;
        d_in    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 2100 && int'(dut0.u_pwm.cnt) != v; i++) @(negedge clk);
        checks++;
        if (int'(dut0.u_pwm.cnt) != v) begin
            errors++;
            $display("FAIL wait_cnt got cnt=%0d expected %0d within budget", dut0.u_pwm.cnt, v);
        end
    endtask

    // call at the negedge where cnt==1: pwm_out there reflects cnt 0 of the period
    task automatic count_high(output int n0, output int nd);
        n0 = 0;
        nd = 0;
        for (int i = 0; i < 1024; i++) begin
            n0 += int'(p0);
            nd += int'(pd);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({a0, v0, s0, p0} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got audio=%0d vld=%0b sat=%0b pwm=%0b expected all 0", a0, v0, s0, p0);
        end
        checks++;
        if (dut0.u_pwm.duty !== 10'd512 || dut0.u_pwm.cnt !== 10'd0 || dut0.acc !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got duty=%0d cnt=%0d acc=%0d expected 512 0 0",
                     dut0.u_pwm.duty, dut0.u_pwm.cnt, dut0.acc);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_sample();
        apply_reset();
        drive(1'b1, 12'd1000);
        checks++;
        if (v0 !== 1'b0 || dut0.acc !== 22'd1000) begin
            errors++;
            $display("FAIL first_s1 got vld=%0b acc=%0d expected vld=0 acc=1000", v0, dut0.acc);
        end
        drive(1'b0, 12'd0);
        checks++;
        if (v0 !== 1'b1 || a0 !== 12'd1000 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL first_out got vld=%0b audio=%0d sat=%0b expected 1 1000 0", v0, $signed(a0), s0);
        end
        checks++;
        if (vg !== 1'b1 || ag !== 12'd2047 || sg !== 1'b1) begin
            errors++;
            $display("FAIL gain_sat got vld=%0b audio=%0d sat=%0b expected 1 2047 1", vg, $signed(ag), sg);
        end
        drive(1'b0, 12'd0);
        checks++;
        if (v0 !== 1'b0 || a0 !== 12'd1000) begin
            errors++;
            $display("FAIL first_hold got vld=%0b audio=%0d expected vld=0 audio=1000", v0, $signed(a0));
        end
    endtask

    task automatic test_dc0_sat();
        apply_reset();
        drive(1'b1, 12'd4095);
        drive(1'b1, 12'd0);
        checks++;
        if (vd !== 1'b1 || ad !== 12'd2047 || sd !== 1'b1) begin
            errors++;
            $display("FAIL dc0_pos got vld=%0b audio=%0d sat=%0b expected 1 2047 1", vd, $signed(ad), sd);
        end
        drive(1'b0, 12'd0);
        checks++;
        if (vd !== 1'b1 || ad !== 12'h800 || sd !== 1'b1) begin
            errors++;
            $display("FAIL dc0_neg got vld=%0b audio=%0d sat=%0b expected 1 -2048 1", vd, $signed(ad), sd);
        end
        drive(1'b0, 12'd0);
        checks++;
        if (vd !== 1'b0 || sd !== 1'b0 || ad !== 12'h800) begin
            errors++;
            $display("FAIL dc0_hold got vld=%0b sat=%0b audio=%0d expected 0 0 -2048", vd, sd, $signed(ad));
        end
    endtask

    task automatic test_decay();
        int prev, viol, late_sat, nv, a;
        apply_reset();
        prev = 2047;
        viol = 0;
        late_sat = 0;
        nv = 0;
        for (int i = 0; i < 20003; i++) begin
            drive(i < 20000, 12'd2048);
            if (v0 === 1'b1) begin
                a = int'($signed(a0));
                if (a > prev) viol++;
                // the very first sample meets a zero DC estimate and sits one past full scale
                if (nv > 0 && s0 !== 1'b0) late_sat++;
                prev = a;
                nv++;
            end
        end
        checks++;
        if (nv != 20000 || viol != 0) begin
            errors++;
            $display("FAIL decay_mono got samples=%0d increases=%0d expected 20000 0", nv, viol);
        end
        checks++;
        if (late_sat != 0) begin
            errors++;
            $display("FAIL decay_sat got %0d sat strobes after the first sample expected 0", late_sat);
        end
        checks++;
        if (prev > 2 || prev < -2) begin
            errors++;
            $display("FAIL decay_final got audio=%0d expected |audio|<=2", prev);
        end
    endtask

    task automatic pwm_level(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] exp_audio, input int exp_duty);
        logic [9:0] hold;
        int bad, n0, nd;
        wait_cnt(100);
        drive(1'b1, a);
        drive(1'b1, b);
        drive(1'b0, 12'd0);
        checks++;
        if (vd !== 1'b1 || ad !== exp_audio) begin
            errors++;
            $display("FAIL pwm_audio got vld=%0b audio=%0d expected 1 %0d", vd, $signed(ad), $signed(exp_audio));
        end
        drive(1'b0, 12'd0);
        hold = dut_d.u_pwm.duty;
        bad = 0;
        for (int i = 0; i < 1100 && dut0.u_pwm.cnt != 10'd0; i++) begin
            if (dut_d.u_pwm.duty !== hold) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || int'(dut_d.u_pwm.duty) != exp_duty) begin
            errors++;
            $display("FAIL pwm_duty_load got mid-period changes=%0d duty=%0d expected 0 %0d",
                     bad, dut_d.u_pwm.duty, exp_duty);
        end
        @(negedge clk);
        count_high(n0, nd);
        checks++;
        if (nd != exp_duty) begin
            errors++;
            $display("FAIL pwm_high got %0d high cycles expected %0d", nd, exp_duty);
        end
    endtask

    task automatic test_pwm_levels();
        apply_reset();
        pwm_level(12'd1000, 12'd1000, 12'd0,    512);
        pwm_level(12'd4095, 12'd0,    12'h800,  0);
        pwm_level(12'd0,    12'd2047, 12'd2047, 1023);
        pwm_level(12'd2048, 12'd2548, 12'd500,  637);
    endtask

    task automatic test_wrap_cycle();
        int n0, nd;
        wait_cnt(1021);
        drive(1'b1, 12'd3548);
        drive(1'b0, 12'd0);
        checks++;
        if (dut0.u_pwm.cnt !== 10'd1023 || vd !== 1'b1 || ad !== 12'd1000) begin
            errors++;
            $display("FAIL wrap_setup got cnt=%0d vld=%0b audio=%0d expected 1023 1 1000",
                     dut0.u_pwm.cnt, vd, $signed(ad));
        end
        drive(1'b0, 12'd0);
        checks++;
        if (dut_d.u_pwm.duty !== 10'd637 || dut_d.u_pwm.pend !== 10'd762) begin
            errors++;
            $display("FAIL wrap_load got duty=%0d pend=%0d expected 637 762",
                     dut_d.u_pwm.duty, dut_d.u_pwm.pend);
        end
        @(negedge clk);
        count_high(n0, nd);
        checks++;
        if (nd != 637) begin
            errors++;
            $display("FAIL wrap_old_period got %0d high cycles expected 637", nd);
        end
        count_high(n0, nd);
        checks++;
        if (nd != 762) begin
            errors++;
            $display("FAIL wrap_new_period got %0d high cycles expected 762", nd);
        end
    endtask

    task automatic test_reset_mid();
        int n0, nd, stale;
        wait_cnt(100);
        drive(1'b1, 12'd1000);
        drive(1'b1, 12'd3000);
        checks++;
        if (pd !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_pwm got pwm=%0b expected 1", pd);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, v0, s0, p0, pd, ad} !== 28'd0) begin
            errors++;
            $display("FAIL mid_async_out got audio=%0d vld=%0b sat=%0b pwm0=%0b pwmd=%0b audiod=%0d expected all 0",
                     a0, v0, s0, p0, pd, ad);
        end
        checks++;
        if (dut0.u_pwm.cnt !== 10'd0 || dut0.u_pwm.duty !== 10'd512 || dut0.acc !== 22'd0) begin
            errors++;
            $display("FAIL mid_async_state got cnt=%0d duty=%0d acc=%0d expected 0 512 0",
                     dut0.u_pwm.cnt, dut0.u_pwm.duty, dut0.acc);
        end
        sb.delete();
        acc_m   = 0;
        d_valid = 1'b0;
        d_in    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            stale += int'(v0) + int'(vd) + int'(vg);
            @(negedge clk);
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mid_stale_vld got %0d strobes after release expected 0", stale);
        end
        wait_cnt(1);
        count_high(n0, nd);
        checks++;
        if (n0 != 512 || nd != 512) begin
            errors++;
            $display("FAIL mid_first_period got high=%0d/%0d expected 512/512", n0, nd);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        d_valid = 1'b0;
        d_in    = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_first_sample();
        test_dc0_sat();
        test_decay();
        test_pwm_levels();
        test_wrap_cycle();
        test_reset_mid();
        drive(1'b0, 12'd0);
        drive(1'b0, 12'd0);
        drive(1'b0, 12'd0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d samples without a strobe expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
